// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared opcode values, arbiter FSM states and ALU flag positions
// for the ALU-sharing front end (alu_arbiter).
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_GT   = 4'b1000;
    localparam logic [3:0] OP_LT   = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_NAND = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_IDLE = 4'b1111;

    // Bit positions within the {Arith,Logic,CMP,Shift} flag nibble.
    localparam int unsigned FLAG_ARITH = 3;
    localparam int unsigned FLAG_LOGIC = 2;
    localparam int unsigned FLAG_CMP   = 1;
    localparam int unsigned FLAG_SHIFT = 0;

    localparam logic [15:0] DIV0_DATA  = 16'hFFFF;
    localparam logic [3:0]  DIV0_FLAGS = 4'(1 << FLAG_ARITH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
    } alu_op_t;

    function automatic logic is_div0(input logic [3:0] fun, input logic [15:0] b);
        return (fun == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first asserted request
// at or after the pointer, returned both one-hot and as an index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        k         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!grant_any && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = k;
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered 16-bit ALU between NUM_REQ requesters, one op in flight.
// Define ALU_ARB_DIV0_CHK_EN to answer divide-by-zero locally without using the ALU.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_W     = 2,
    parameter logic [3:0]  IDLE_FUN = OP_IDLE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*16-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]    req_fun,
    output logic [15:0]             alu_a,
    output logic [15:0]             alu_b,
    output logic [3:0]              alu_fun,
    input  logic [15:0]             alu_out,
    input  logic [3:0]              alu_flags,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [15:0]             rsp_data,
    output logic [3:0]              rsp_flags,
    output logic                    rsp_err
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [15:0]         alu_a_q, alu_a_d;
    logic [15:0]         alu_b_q, alu_b_d;
    logic [3:0]          alu_fun_q, alu_fun_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [15:0]         rsp_data_q, rsp_data_d;
    logic [3:0]          rsp_flags_q, rsp_flags_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                grant_any;
    logic [ID_W-1:0]     ptr_next;
    alu_op_t             sel_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op.a   = req_a[16*i +: 16];
                sel_op.b   = req_b[16*i +: 16];
                sel_op.fun = req_fun[4*i +: 4];
            end
        end
    end

    assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Accept strobe exists only in IDLE and is held off while reset is asserted.
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    id_d  = grant_idx;
                    ptr_d = ptr_next;
`ifdef ALU_ARB_DIV0_CHK_EN
                    if (is_div0(sel_op.fun, sel_op.b)) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant_idx;
                        rsp_data_d  = DIV0_DATA;
                        rsp_flags_d = DIV0_FLAGS;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = ST_ISSUE;
                        alu_a_d   = sel_op.a;
                        alu_b_d   = sel_op.b;
                        alu_fun_d = sel_op.fun;
                    end
`else
                    state_d   = ST_ISSUE;
                    alu_a_d   = sel_op.a;
                    alu_b_d   = sel_op.b;
                    alu_fun_d = sel_op.fun;
`endif
                end
            end
            ST_ISSUE: begin
                // ALU samples its inputs at the end of ISSUE; park the opcode for WAIT.
                state_d   = ST_WAIT;
                alu_fun_d = IDLE_FUN;
            end
            ST_WAIT: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = alu_out;
                rsp_flags_d = alu_flags;
                rsp_err_d   = 1'b0;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = '0;
                    rsp_data_d  = '0;
                    rsp_flags_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= IDLE_FUN;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives alu_arbiter with a registered ALU model and checks grants,
// timing and tagged responses against a transaction-level reference.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic [NUM_REQ*4-1:0]  req_fun;
    logic [15:0]           alu_a, alu_b, alu_out;
    logic [3:0]            alu_fun, alu_flags;
    logic                  rsp_valid, rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_data;
    logic [3:0]            rsp_flags;
    logic                  rsp_err;

    int checks   = 0;
    int failures = 0;
    int mptr     = 0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_W     (ID_W),
        .IDLE_FUN (4'b1111)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_fun   (req_fun),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_out   (alu_out),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err)
    );

    // Behavioural 16-bit ALU: returns {flags, result}.
    function automatic logic [19:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] fun);
        logic [15:0] r;
        logic [3:0]  f;
        r = '0;
        f = '0;
        case (fun)
            4'h0: begin r = a + b;                       f = 4'b1000; end
            4'h1: begin r = a - b;                       f = 4'b1000; end
            4'h2: begin r = a * b;                       f = 4'b1000; end
            4'h3: begin r = (b == 0) ? 16'h0000 : a / b; f = 4'b1000; end
            4'h4: begin r = a & b;                       f = 4'b0100; end
            4'h5: begin r = a | b;                       f = 4'b0100; end
            4'h6: begin r = a ^ b;                       f = 4'b0100; end
            4'h7: begin r = ~a;                          f = 4'b0100; end
            4'h8: begin r = {15'd0, a > b};              f = 4'b0010; end
            4'h9: begin r = {15'd0, a < b};              f = 4'b0010; end
            4'hA: begin r = {15'd0, a == b};             f = 4'b0010; end
            4'hB: begin r = ~(a & b);                    f = 4'b0100; end
            4'hC: begin r = ~(a | b);                    f = 4'b0100; end
            4'hD: begin r = a >> b[3:0];                 f = 4'b0001; end
            4'hE: begin r = a << b[3:0];                 f = 4'b0001; end
            default: ;
        endcase
        return {f, r};
    endfunction

    always @(posedge clk) {alu_flags, alu_out} <= alu_calc(alu_a, alu_b, alu_fun);

    // Expected {err, flags, data} for an accepted request.
    function automatic logic [20:0] exp_rsp(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] fun);
`ifdef ALU_ARB_DIV0_CHK_EN
        if (fun == 4'h3 && b == 16'h0000) return {1'b1, 4'b1000, 16'hFFFF};
`endif
        return {1'b0, alu_calc(a, b, fun)};
    endfunction

    function automatic int exp_lat(input logic [15:0] b, input logic [3:0] fun);
`ifdef ALU_ARB_DIV0_CHK_EN
        if (fun == 4'h3 && b == 16'h0000) return 1;
`endif
        return 3;
    endfunction

    // Round-robin rule: first valid requester at or after the pointer, wrapping.
    function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] f);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_fun[4*i +: 4] = f;
    endtask

    task automatic do_reset();
        step();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        rst  = 1'b0;
        mptr = 0;
    endtask

    // Counts negedges from the accept cycle until rsp_valid, bounded by budget.
    task automatic wait_rsp(input int budget, output int cyc, output logic [NUM_REQ-1:0] seen);
        cyc  = 0;
        seen = '0;
        do begin
            @(negedge clk);
            cyc++;
            if (rsp_valid !== 1'b1) seen |= req_ready;
        end while (rsp_valid !== 1'b1 && cyc < budget);
    endtask

    task automatic finish_rsp();
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({req_ready, alu_a, alu_b, alu_fun} !== {4'b0000, 16'h0, 16'h0, 4'hF})
            $display("FAIL reset_alu: ready=%b a=%h b=%h fun=%h, expected ready=0000 a=0 b=0 fun=f",
                     req_ready, alu_a, alu_b, alu_fun);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err} !== '0)
            $display("FAIL reset_rsp: valid=%b id=%0d data=%h flags=%b err=%b, expected all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err);
        step();
        rst       = 1'b0;
        req_valid = '0;
        mptr      = 0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, alu_fun} !== {4'b0000, 1'b0, 4'hF})
            $display("FAIL reset_release: ready=%b rsp_valid=%b fun=%h, expected 0000 0 f",
                     req_ready, rsp_valid, alu_fun);
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || alu_fun !== 4'hF) failures++;
    endtask

    task automatic test_single();
        step();
        set_op(0, 16'd5, 16'd3, 4'b0000);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: ready=%b, expected 0001", req_ready);
        end
        mptr = 1;
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({alu_a, alu_b, alu_fun, req_ready} !== {16'd5, 16'd3, 4'h0, 4'b0000}) begin
            failures++;
            $display("FAIL single_issue: a=%h b=%h fun=%h ready=%b, expected 0005 0003 0 0000",
                     alu_a, alu_b, alu_fun, req_ready);
        end
        @(negedge clk);
        checks++;
        if ({alu_fun, rsp_valid} !== {4'hF, 1'b0}) begin
            failures++;
            $display("FAIL single_wait: fun=%h rsp_valid=%b, expected f 0", alu_fun, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err} !== {1'b1, 2'd0, 16'd8, 4'b1000, 1'b0}) begin
            failures++;
            $display("FAIL single_rsp: valid=%b id=%0d data=%h flags=%b err=%b, expected 1 0 0008 1000 0",
                     rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err);
        end
        finish_rsp();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done: rsp_valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int cyc, g, lat;
        logic [NUM_REQ-1:0] seen;
        logic [20:0] e;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 16'($urandom), 16'($urandom), 4'b0100);
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 2 * NUM_REQ + 1; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (req_ready === '0 && cyc < 8);
            g = exp_grant(req_valid, mptr);
            checks++;
            if (req_ready !== 4'(1 << (k % NUM_REQ)) || req_ready !== 4'(1 << g)) begin
                failures++;
                $display("FAIL rr_grant_%0d: ready=%b, expected one-hot of requester %0d",
                         k, req_ready, k % NUM_REQ);
            end
            mptr = (g + 1) % NUM_REQ;
            e = exp_rsp(req_a[16*g +: 16], req_b[16*g +: 16], req_fun[4*g +: 4]);
            wait_rsp(8, lat, seen);
            checks++;
            if (rsp_valid !== 1'b1 || lat != 3 || seen !== '0 || rsp_id !== 2'(g) ||
                {rsp_err, rsp_flags, rsp_data} !== e) begin
                failures++;
                $display("FAIL rr_rsp_%0d: valid=%b lat=%0d seen=%b id=%0d rsp=%h, expected 1 3 0000 %0d %h",
                         k, rsp_valid, lat, seen, rsp_id, {rsp_err, rsp_flags, rsp_data}, g, e);
            end
        end
        finish_rsp();
    endtask

    task automatic test_backpressure();
        int lat, g;
        logic [NUM_REQ-1:0] seen;
        step();
        set_op(2, 16'hFFFF, 16'h0001, 4'b1101);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        @(negedge clk);
        g = exp_grant(req_valid, mptr);
        checks++;
        if (req_ready !== 4'(1 << g)) begin
            failures++;
            $display("FAIL bp_grant: ready=%b, expected 0100", req_ready);
        end
        mptr = (g + 1) % NUM_REQ;
        step();
        req_valid = '1;
        wait_rsp(8, lat, seen);
        checks++;
        if (rsp_valid !== 1'b1 || lat != 3 || seen !== '0) begin
            failures++;
            $display("FAIL bp_latency: valid=%b lat=%0d seen=%b, expected 1 3 0000", rsp_valid, lat, seen);
        end
        for (int s = 0; s < 5; s++) begin
            if (s > 0) step();
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_data, req_ready} !==
                {1'b1, 2'd2, 1'b0, 4'b0001, 16'h7FFF, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold_%0d: valid=%b id=%0d err=%b flags=%b data=%h ready=%b, expected 1 2 0 0001 7fff 0000",
                         s, rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_data, req_ready);
            end
        end
        finish_rsp();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done: rsp_valid=%b, expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat, g;
        logic [NUM_REQ-1:0] seen;
        step();
        set_op(2, 16'h1234, 16'h1111, 4'b0000);
        set_op(0, 16'h0020, 16'h0003, 4'b0001);
        set_op(3, 16'h0040, 16'h0004, 4'b0101);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        step();
        req_valid = '0;
        @(negedge clk);
        step();
        rst = 1'b1;
        @(negedge clk);
        step();
        rst       = 1'b0;
        req_valid = 4'b1001;
        mptr      = 0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_fun} !==
            {1'b0, 2'd0, 16'h0, 4'h0, 1'b0, 16'h0, 16'h0, 4'hF}) begin
            failures++;
            $display("FAIL rstmid_outputs: rsp_valid=%b data=%h alu_a=%h alu_b=%h fun=%h, expected 0 0000 0000 0000 f",
                     rsp_valid, rsp_data, alu_a, alu_b, alu_fun);
        end
        g = exp_grant(req_valid, mptr);
        checks++;
        if (req_ready !== 4'(1 << g)) begin
            failures++;
            $display("FAIL rstmid_grant: ready=%b, expected 0001", req_ready);
        end
        mptr = (g + 1) % NUM_REQ;
        step();
        req_valid = '0;
        wait_rsp(8, lat, seen);
        checks++;
        if (rsp_valid !== 1'b1 || lat != 3 || rsp_id !== 2'd0 ||
            {rsp_err, rsp_flags, rsp_data} !== {1'b0, 4'b1000, 16'h001D}) begin
            failures++;
            $display("FAIL rstmid_rsp: valid=%b lat=%0d id=%0d rsp=%h, expected 1 3 0 %h",
                     rsp_valid, lat, rsp_id, {rsp_err, rsp_flags, rsp_data}, {1'b0, 4'b1000, 16'h001D});
        end
        finish_rsp();
    endtask

    task automatic test_single_op(input string name, input int r, input logic [15:0] a,
                                  input logic [15:0] b, input logic [3:0] f);
        int lat, g;
        logic [NUM_REQ-1:0] seen;
        logic [20:0] e;
        step();
        set_op(r, a, b, f);
        req_valid = 4'(1 << r);
        rsp_ready = 1'b0;
        @(negedge clk);
        g = exp_grant(req_valid, mptr);
        checks++;
        if (req_ready !== 4'(1 << g)) begin
            failures++;
            $display("FAIL %s_grant: ready=%b, expected requester %0d", name, req_ready, g);
        end
        mptr = (g + 1) % NUM_REQ;
        e = exp_rsp(a, b, f);
        step();
        req_valid = '0;
        wait_rsp(8, lat, seen);
        checks++;
        if (rsp_valid !== 1'b1 || lat != exp_lat(b, f) || rsp_id !== 2'(r) || alu_fun !== 4'hF ||
            {rsp_err, rsp_flags, rsp_data} !== e) begin
            failures++;
            $display("FAIL %s_rsp: valid=%b lat=%0d id=%0d fun=%h rsp=%h, expected 1 %0d %0d f %h",
                     name, rsp_valid, lat, rsp_id, alu_fun, {rsp_err, rsp_flags, rsp_data},
                     exp_lat(b, f), r, e);
        end
        finish_rsp();
    endtask

    task automatic test_random();
        int lat, g, stall;
        logic [NUM_REQ-1:0] seen, v;
        logic [20:0] e;
        for (int it = 0; it < 40; it++) begin
            step();
            v = 4'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++)
                set_op(i, 16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                       4'($urandom));
            req_valid = v;
            rsp_ready = 1'b0;
            @(negedge clk);
            g = exp_grant(v, mptr);
            checks++;
            if (req_ready !== 4'(1 << g)) begin
                failures++;
                $display("FAIL rand_grant_%0d: valid=%b ready=%b, expected requester %0d",
                         it, v, req_ready, g);
            end
            mptr = (g + 1) % NUM_REQ;
            e = exp_rsp(req_a[16*g +: 16], req_b[16*g +: 16], req_fun[4*g +: 4]);
            lat = exp_lat(req_b[16*g +: 16], req_fun[4*g +: 4]);
            step();
            req_valid = '0;
            wait_rsp(8, stall, seen);
            checks++;
            if (rsp_valid !== 1'b1 || stall != lat || seen !== '0 || rsp_id !== 2'(g) ||
                {rsp_err, rsp_flags, rsp_data} !== e) begin
                failures++;
                $display("FAIL rand_rsp_%0d: valid=%b lat=%0d seen=%b id=%0d rsp=%h, expected 1 %0d 0000 %0d %h",
                         it, rsp_valid, stall, seen, rsp_id, {rsp_err, rsp_flags, rsp_data}, lat, g, e);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                step();
                req_valid = 4'($urandom);
                @(negedge clk);
                checks++;
                if (rsp_valid !== 1'b1 || req_ready !== '0 || rsp_id !== 2'(g) ||
                    {rsp_err, rsp_flags, rsp_data} !== e) begin
                    failures++;
                    $display("FAIL rand_hold_%0d: valid=%b ready=%b id=%0d rsp=%h, expected 1 0000 %0d %h",
                             it, rsp_valid, req_ready, rsp_id, {rsp_err, rsp_flags, rsp_data}, g, e);
                end
            end
            finish_rsp();
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rand_done_%0d: rsp_valid=%b, expected 0", it, rsp_valid);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_fun   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_single_op("div0", 1, 16'd10, 16'd0, 4'b0011);
        test_single_op("idle_op", 3, 16'd7, 16'd7, 4'b1111);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
